// File: rtl/pdm_cic_decimator_if.sv
// PDM microphone / PCM stream bundle for pdm_cic_decimator.
// master: the decimator side; slave: the controller/consumer side.
interface pdm_cic_decimator_if;
  logic               enable;
  logic               mic_data;
  logic               mic_clk;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;
  logic               pcm_ready;
  logic               overrun;

  modport master (
    input  enable,
    input  mic_data,
    input  pcm_ready,
    output mic_clk,
    output pcm_data,
    output pcm_valid,
    output overrun
  );

  modport slave (
    output enable,
    output mic_data,
    output pcm_ready,
    input  mic_clk,
    input  pcm_data,
    input  pcm_valid,
    input  overrun
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: mic clock divider, 3rd-order CIC decimator, valid/ready PCM output.
// Define PDM_DC_BLOCK_EN to insert a one-pole DC-removal stage after saturation.
module pdm_cic_decimator #(
  parameter int unsigned CLK_DIV = 42,
  parameter int unsigned DECIM   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pdm_cic_decimator_if.master  bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned DecW = $clog2(DECIM);
  localparam int          LogD = $clog2(DECIM);
  // CIC gain is DECIM^3; normalise it to 2^15 (shift right for large DECIM, left for small).
  localparam int          ShR  = (3 * LogD > 15) ? (3 * LogD - 15) : 0;
  localparam int          ShL  = (3 * LogD < 15) ? (15 - 3 * LogD) : 0;

  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic               r_mic_clk;
  logic               r_en_q;
  logic [DecW-1:0]    r_dec_cnt;
  logic [1:0]         r_warm;
  logic signed [19:0] r_int1, r_int2, r_int3;
  logic signed [19:0] r_dly1, r_dly2, r_dly3;
  logic signed [19:0] w_comb1, w_comb2, w_comb3;
  logic signed [1:0]  w_bit;
  logic signed [19:0] w_bit_ext;
  logic signed [31:0] w_wide, w_scaled;
  logic signed [15:0] w_sat;
  logic               w_en_rise, w_bit_stb, w_dec_stb, w_post_warm;
  logic               w_new;
  logic signed [15:0] w_new_data;
  logic signed [15:0] r_pcm_data;
  logic               r_pcm_valid;
  logic               r_overrun;

  always_comb begin
    w_en_rise   = bus.enable & ~r_en_q;
    w_bit_stb   = bus.enable && (r_cnt == CntW'(CLK_DIV - 1));
    w_dec_stb   = w_bit_stb && (r_dec_cnt == DecW'(DECIM - 1));
    w_post_warm = w_dec_stb && (r_warm == 2'd3);
    w_cnt_nxt   = '0;
    if (bus.enable && (r_cnt != CntW'(CLK_DIV - 1))) w_cnt_nxt = r_cnt + CntW'(1);
    w_bit       = bus.mic_data ? 2'sb01 : 2'sb11;
    w_bit_ext   = {{18{w_bit[1]}}, w_bit};
    w_comb1     = r_int3 - r_dly1;
    w_comb2     = w_comb1 - r_dly2;
    w_comb3     = w_comb2 - r_dly3;
    w_wide      = {{12{w_comb3[19]}}, w_comb3};
    w_scaled    = (w_wide >>> ShR) <<< ShL;
    if (w_scaled > 32'sd32767)       w_sat = 16'sh7fff;
    else if (w_scaled < -32'sd32768) w_sat = 16'sh8000;
    else                             w_sat = w_scaled[15:0];
  end

  // Divider, integrators (per bit strobe) and combs (per decimation strobe).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mic_clk <= 1'b0;
      r_dec_cnt <= '0;
      r_warm    <= 2'd0;
      r_int1    <= '0;
      r_int2    <= '0;
      r_int3    <= '0;
      r_dly1    <= '0;
      r_dly2    <= '0;
      r_dly3    <= '0;
    end else if (!bus.enable) begin
      r_cnt     <= '0;
      r_mic_clk <= 1'b0;
      r_dec_cnt <= '0;
      r_warm    <= 2'd0;
      r_int1    <= '0;
      r_int2    <= '0;
      r_int3    <= '0;
      r_dly1    <= '0;
      r_dly2    <= '0;
      r_dly3    <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_mic_clk <= (w_cnt_nxt >= CntW'(CLK_DIV / 2));
      if (w_bit_stb) begin
        r_int1    <= r_int1 + w_bit_ext;
        r_int2    <= r_int2 + r_int1;
        r_int3    <= r_int3 + r_int2;
        r_dec_cnt <= r_dec_cnt + DecW'(1);
      end
      if (w_dec_stb) begin
        r_dly1 <= r_int3;
        r_dly2 <= w_comb1;
        r_dly3 <= w_comb2;
        if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      end
    end
  end

`ifdef PDM_DC_BLOCK_EN
  logic               r_dc_vld;
  logic signed [15:0] r_dc_x, r_dc_xprev, r_dc_yprev;
  logic signed [23:0] w_dc_x, w_dc_xp, w_dc_yp, w_dc_sum;
  logic signed [15:0] w_dc_y;

  always_comb begin
    w_dc_x   = {{8{r_dc_x[15]}}, r_dc_x};
    w_dc_xp  = {{8{r_dc_xprev[15]}}, r_dc_xprev};
    w_dc_yp  = {{8{r_dc_yprev[15]}}, r_dc_yprev};
    w_dc_sum = w_dc_x - w_dc_xp + w_dc_yp - (w_dc_yp >>> 8);
    if (w_dc_sum > 24'sd32767)       w_dc_y = 16'sh7fff;
    else if (w_dc_sum < -24'sd32768) w_dc_y = 16'sh8000;
    else                             w_dc_y = w_dc_sum[15:0];
    w_new      = r_dc_vld;
    w_new_data = w_dc_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dc_vld   <= 1'b0;
      r_dc_x     <= '0;
      r_dc_xprev <= '0;
      r_dc_yprev <= '0;
    end else if (w_en_rise) begin
      r_dc_vld   <= 1'b0;
      r_dc_xprev <= '0;
      r_dc_yprev <= '0;
    end else begin
      r_dc_vld <= w_post_warm;
      if (w_post_warm) r_dc_x <= w_sat;
      if (r_dc_vld) begin
        r_dc_xprev <= r_dc_x;
        r_dc_yprev <= w_dc_y;
      end
    end
  end
`else
  always_comb begin
    w_new      = w_post_warm;
    w_new_data = w_sat;
  end
`endif

  // Single-entry output register; a sample arriving into a stalled slot is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_q      <= 1'b0;
      r_pcm_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_en_q <= bus.enable;
      if (w_new && (!r_pcm_valid || bus.pcm_ready)) begin
        r_pcm_data  <= w_new_data;
        r_pcm_valid <= 1'b1;
      end else begin
        if (r_pcm_valid && bus.pcm_ready) r_pcm_valid <= 1'b0;
        if (w_new) r_overrun <= 1'b1;
      end
      if (w_en_rise) r_overrun <= 1'b0;
    end
  end

  assign bus.mic_clk   = r_mic_clk;
  assign bus.pcm_data  = r_pcm_data;
  assign bus.pcm_valid = r_pcm_valid;
  assign bus.overrun   = r_overrun;

endmodule
